// File: rtl/nq_pipe_pkg.sv
// Shared encodings for the NanoQuarter pipeline sequencer.
package nq_pipe_pkg;

  localparam int REG_AW_DEF = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_JMP = 2'd1;
  localparam logic [1:0] PCSEL_BR  = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard terms gathered from decode, execute and memory stages.
module hazard_detect #(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_jmp,
  input  logic              ex_bne_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              loaduse_o,
  output logic              redirect_o,
  output logic              memwait_o
);

  assign memwait_o  = mem_req & ~mem_ready;
  assign redirect_o = ex_jmp | ex_bne_taken;
  assign loaduse_o  = ex_memread & ((id_use_rs & (id_rs == ex_rd)) |
                                    (id_use_rt & (id_rt == ex_rd)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: PC/decode-execute register controls, next-PC select,
// load-use stalls, redirect flushes and multi-cycle memory waits.
module pipe_hazard_ctrl
  import nq_pipe_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int FLUSH_DEPTH = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_jmp,
  input  logic              ex_bne_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              s1_en,
  output logic              s1_flush,
  output logic [1:0]        pc_sel,
  output logic [15:0]       stall_cnt,
  output logic              mem_err,
  output logic [1:0]        state_o
);

  logic loaduse, redirect, memwait;

  hazard_detect #(.REG_AW(REG_AW)) u_hd (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .ex_rd        (ex_rd),
    .ex_memread   (ex_memread),
    .ex_jmp       (ex_jmp),
    .ex_bne_taken (ex_bne_taken),
    .mem_req      (mem_req),
    .mem_ready    (mem_ready),
    .loaduse_o    (loaduse),
    .redirect_o   (redirect),
    .memwait_o    (memwait)
  );

  state_e      state_q, state_d;
  logic [3:0]  fcnt_q, fcnt_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [15:0] stall_q;
  logic        merr_q, merr_d;
  logic        pc_en_c, s1_en_c, s1_flush_c;
  logic [1:0]  pc_sel_c;

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    wcnt_d     = wcnt_q;
    merr_d     = merr_q;
    pc_en_c    = 1'b1;
    s1_en_c    = 1'b1;
    s1_flush_c = 1'b0;
    pc_sel_c   = PCSEL_SEQ;
    if (state_q == MEM_WAIT) begin
      pc_en_c = 1'b0;
      s1_en_c = 1'b0;
      if (mem_ready) begin
        state_d = RUN;
      end else if (wcnt_q == 8'(MEM_TIMEOUT)) begin
        merr_d  = 1'b1;
        state_d = RUN;
      end else begin
        wcnt_d = wcnt_q + 8'd1;
      end
    end else if (memwait) begin
      // A stalled memory stage freezes everything, abandoning any flush/stall.
      pc_en_c = 1'b0;
      s1_en_c = 1'b0;
      state_d = MEM_WAIT;
      wcnt_d  = 8'd1;
    end else begin
      case (state_q)
        FLUSH: begin
          // Execute holds a bubble here, so a redirect cannot be genuine.
          s1_flush_c = 1'b1;
          if (fcnt_q <= 4'd1) state_d = RUN;
          else                fcnt_d  = fcnt_q - 4'd1;
        end
        LU_STALL: state_d = RUN;
        default: begin
          if (redirect) begin
            s1_flush_c = 1'b1;
            pc_sel_c   = ex_jmp ? PCSEL_JMP : PCSEL_BR;
            if (FLUSH_DEPTH > 1) begin
              state_d = FLUSH;
              fcnt_d  = 4'(FLUSH_DEPTH - 1);
            end
          end else if (loaduse) begin
            pc_en_c    = 1'b0;
            s1_flush_c = 1'b1;
            state_d    = LU_STALL;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      wcnt_q  <= '0;
      stall_q <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      wcnt_q  <= wcnt_d;
      merr_q  <= merr_d;
      if (!pc_en_c && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign pc_en     = rst ? 1'b0 : pc_en_c;
  assign s1_en     = rst ? 1'b0 : s1_en_c;
  assign s1_flush  = rst ? 1'b1 : s1_flush_c;
  assign pc_sel    = rst ? PCSEL_SEQ : pc_sel_c;
  assign stall_cnt = stall_q;
  assign mem_err   = merr_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed plus random bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int AW = 3, FD = 2, TO = 4;

  logic clk = 1'b0;
  logic rst;
  logic [AW-1:0] id_rs, id_rt, ex_rd;
  logic id_use_rs, id_use_rt, ex_memread, ex_jmp, ex_bne_taken, mem_req, mem_ready;
  logic pc_en, s1_en, s1_flush, mem_err;
  logic [1:0] pc_sel, state_o;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .FLUSH_DEPTH(FD), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_jmp(ex_jmp),
    .ex_bne_taken(ex_bne_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .s1_en(s1_en), .s1_flush(s1_flush), .pc_sel(pc_sel),
    .stall_cnt(stall_cnt), .mem_err(mem_err), .state_o(state_o)
  );

  int errs = 0, checks = 0;
  // Reference model: mode 0 run, 1 after load-use bubble, 2 waiting on memory, 3 flushing
  int m_mode = 0, m_flush_left = 0, m_waited = 0, m_stall = 0;
  bit m_err = 0, m_known = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; id_use_rs = 0; id_use_rt = 0;
    ex_memread = 0; ex_jmp = 0; ex_bne_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic cyc();
    bit mw, rd, lu;
    logic e_pc, e_s1, e_fl;
    logic [1:0] e_sel;
    int n_mode, n_left, n_wait;
    bit n_err;
    #1;
    mw = mem_req && !mem_ready;
    rd = ex_jmp || ex_bne_taken;
    lu = ex_memread && ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    e_pc = 1; e_s1 = 1; e_fl = 0; e_sel = 0;
    n_mode = 0; n_left = m_flush_left; n_wait = m_waited; n_err = m_err;
    if (m_mode == 2) begin
      e_pc = 0; e_s1 = 0;
      if (mem_ready) n_mode = 0;
      else if (m_waited == TO) n_err = 1;
      else begin n_mode = 2; n_wait = m_waited + 1; end
    end else if (mw) begin
      e_pc = 0; e_s1 = 0; n_mode = 2; n_wait = 1;
    end else if (m_mode == 3) begin
      e_fl = 1;
      if (m_flush_left > 1) begin n_mode = 3; n_left = m_flush_left - 1; end
    end else if (m_mode == 1) begin
      n_mode = 0;
    end else if (rd) begin
      e_fl = 1; e_sel = ex_jmp ? 2'd1 : 2'd2;
      if (FD > 1) begin n_mode = 3; n_left = FD - 1; end
    end else if (lu) begin
      e_pc = 0; e_fl = 1; n_mode = 1;
    end
    if (rst) begin e_pc = 0; e_s1 = 0; e_fl = 1; e_sel = 0; end
    chk("pc_en", 32'(pc_en), 32'(e_pc));
    chk("s1_en", 32'(s1_en), 32'(e_s1));
    chk("s1_flush", 32'(s1_flush), 32'(e_fl));
    chk("pc_sel", 32'(pc_sel), 32'(e_sel));
    if (m_known) begin
      chk("state_o", 32'(state_o), 32'(m_mode));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("mem_err", 32'(mem_err), 32'(m_err));
    end
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_flush_left = 0; m_waited = 0; m_stall = 0; m_err = 0; m_known = 1;
    end else begin
      m_mode = n_mode; m_flush_left = n_left; m_waited = n_wait; m_err = n_err;
      if (!e_pc && m_stall < 65535) m_stall++;
    end
    #1;
  endtask

  initial begin
    idle(); rst = 1;
    cyc();
    cyc();
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    rst = 0;

    // load-use: bubble, one normal cycle in LU_STALL, back to RUN
    ex_memread = 1; ex_rd = 3; id_rs = 3; id_use_rs = 1;
    cyc();
    idle();
    chk("lu_state1", 32'(state_o), 32'd1);
    cyc(); cyc();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // taken branch with two-cycle flush
    ex_bne_taken = 1; cyc();
    ex_bne_taken = 0; cyc(); cyc();

    // memory wait of four cycles then ready
    mem_req = 1; mem_ready = 0;
    repeat (4) cyc();
    mem_ready = 1; cyc();
    idle(); cyc();
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd6);
    chk("mw_no_err", 32'(mem_err), 32'd0);

    // memwait + jump + load-use together; jump survives the freeze
    mem_req = 1; mem_ready = 0; ex_jmp = 1;
    ex_memread = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
    cyc(); cyc();
    mem_ready = 1; cyc();
    mem_req = 0; mem_ready = 0; cyc();
    chk("sim_flush_state", 32'(state_o), 32'd3);
    idle(); cyc(); cyc();

    // timeout with memory never ready
    mem_req = 1; mem_ready = 0;
    repeat (6) cyc();
    chk("timeout_err", 32'(mem_err), 32'd1);
    idle(); cyc(); cyc();

    // reset in the middle of a memory wait
    mem_req = 1; mem_ready = 0;
    cyc(); cyc();
    rst = 1; cyc();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    idle(); cyc();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom % 150) == 0;
      mem_req      = ($urandom % 3) == 0;
      mem_ready    = ($urandom % 3) != 0;
      ex_jmp       = ($urandom % 8) == 0;
      ex_bne_taken = ($urandom % 8) == 0;
      ex_memread   = ($urandom % 3) == 0;
      id_use_rs    = $urandom % 2;
      id_use_rt    = $urandom % 2;
      id_rs        = AW'($urandom);
      id_rt        = AW'($urandom);
      ex_rd        = AW'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
